// File: rtl/axi_lite_reg_slave_if.sv
// ---------------------------------------------------------------------------
// axi_lite_reg_slave_if
// AXI4-Lite bus bundle between a master agent and the register-bank slave.
//
// Handshake rule, every channel (AW, W, B, AR, R): the source raises
// *valid and holds the payload stable until it sees *ready high at a rising
// edge. A transfer happens on exactly that edge. Ready may be high before
// valid, and valid never waits on ready.
//
// Signals:
//   AW : awaddr[31:0], awprot[2:0], awvalid  -> slave ; awready <- slave
//   W  : wdata[31:0], wstrb[3:0], wvalid     -> slave ; wready  <- slave
//   B  : bresp[1:0], bvalid                  <- slave ; bready  -> slave
//   AR : araddr[31:0], arprot[2:0], arvalid  -> slave ; arready <- slave
//   R  : rdata[31:0], rresp[1:0], rvalid     <- slave ; rready  -> slave
// ---------------------------------------------------------------------------
interface axi_lite_reg_slave_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_reg_slave
// AXI4-Lite slave holding NUM_REGS 32-bit registers at byte address 4*i,
// with byte strobes and optional read-only slots whose read value comes from
// ro_in. One outstanding write and one outstanding read; the two paths are
// independent and run concurrently.
//
// Ports:
//   aclk        clock, rising edge
//   aresetn     asynchronous active-low reset
//   bus         AXI4-Lite slave modport (AW, W, B, AR, R channels)
//   ro_in       read values for read-only slots, register i on [32i+31:32i]
//   reg_out     register contents, register i on [32i+31:32i], RO slots 0
//   wr_state_o  write FSM state (0 collect, 1 response pending)
//   rd_state_o  read FSM state  (0 address, 1 data pending)
// ---------------------------------------------------------------------------
module axi_lite_reg_slave #(
    parameter int unsigned          NUM_REGS    = 8,
    parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
    parameter logic [31:0]          RESET_VALUE = 32'h0000_0000
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    axi_lite_reg_slave_if.slave      bus,
    input  logic [NUM_REGS*32-1:0]   ro_in,
    output logic [NUM_REGS*32-1:0]   reg_out,
    output logic                     wr_state_o,
    output logic                     rd_state_o
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_ADDR_DATA = 1'b0, W_RESP = 1'b1 } wr_state_e;
    typedef enum logic { R_ADDR      = 1'b0, R_DATA = 1'b1 } rd_state_e;

    // Register storage. RO slots are kept at zero so reg_out reads 0 there.
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wr_state_e   wr_q, wr_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [29:0] aw_idx_q, aw_idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;

    logic        aw_hs, w_hs, commit, wr_ok;
    logic [29:0] c_idx;
    logic [31:0] c_data;
    logic [3:0]  c_strb;

    assign bus.awready = (wr_q == W_ADDR_DATA) && !aw_done_q;
    assign bus.wready  = (wr_q == W_ADDR_DATA) && !w_done_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;

    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid && bus.wready;

    // The write commits on the edge where the later of AW/W completes; the
    // channel completing now contributes its bus value, the other its latch.
    assign commit = (wr_q == W_ADDR_DATA) && (aw_hs || aw_done_q) && (w_hs || w_done_q);
    assign c_idx  = aw_hs ? bus.awaddr[31:2] : aw_idx_q;
    assign c_data = w_hs  ? bus.wdata        : wdata_q;
    assign c_strb = w_hs  ? bus.wstrb        : wstrb_q;

    always_comb begin
        wr_ok = 1'b0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (c_idx == 30'(i) && !RO_MASK[i]) wr_ok = 1'b1;
        end
    end

    always_comb begin
        wr_d      = wr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        aw_idx_d  = aw_idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        case (wr_q)
            W_ADDR_DATA: begin
                if (commit) begin
                    for (int i = 0; i < int'(NUM_REGS); i++) begin
                        if (c_idx == 30'(i) && !RO_MASK[i]) begin
                            for (int k = 0; k < 4; k++) begin
                                if (c_strb[k]) regs_d[i][8*k +: 8] = c_data[8*k +: 8];
                            end
                        end
                    end
                    bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
                    bvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    wr_d      = W_RESP;
                end else begin
                    if (aw_hs) begin
                        aw_done_d = 1'b1;
                        aw_idx_d  = bus.awaddr[31:2];
                    end
                    if (w_hs) begin
                        w_done_d = 1'b1;
                        wdata_d  = bus.wdata;
                        wstrb_d  = bus.wstrb;
                    end
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    bvalid_d = 1'b0;
                    wr_d     = W_ADDR_DATA;
                end
            end
            default: wr_d = W_ADDR_DATA;
        endcase
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_e   rd_q, rd_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    logic        ar_hs, rd_ok;
    logic [29:0] rd_idx;
    logic [31:0] rd_val;

    assign bus.arready = (rd_q == R_ADDR);
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    assign ar_hs  = bus.arvalid && bus.arready;
    assign rd_idx = bus.araddr[31:2];

    // Reads sample regs_q, so a read captured on a commit edge sees the
    // pre-write value.
    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (rd_idx == 30'(i)) begin
                rd_ok  = 1'b1;
                rd_val = RO_MASK[i] ? ro_in[32*i +: 32] : regs_q[i];
            end
        end
    end

    always_comb begin
        rd_d     = rd_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rd_q)
            R_ADDR: begin
                if (ar_hs) begin
                    rdata_d  = rd_val;
                    rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
                    rvalid_d = 1'b1;
                    rd_d     = R_DATA;
                end
            end
            R_DATA: begin
                if (bus.rready) begin
                    rvalid_d = 1'b0;
                    rd_d     = R_ADDR;
                end
            end
            default: rd_d = R_ADDR;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_q      <= W_ADDR_DATA;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rd_q      <= R_ADDR;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= RO_MASK[i] ? 32'h0 : RESET_VALUE;
            end
        end else begin
            wr_q      <= wr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            aw_idx_q  <= aw_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rd_q      <= rd_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_reg_out
        assign reg_out[32*g +: 32] = regs_q[g];
    end

    assign wr_state_o = wr_q;
    assign rd_state_o = rd_q;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{bus.awprot, bus.arprot, bus.awaddr[1:0], bus.araddr[1:0]};

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_reg_slave
// Randomised and directed stimulus against axi_lite_reg_slave (NUM_REGS=8,
// register 1 read-only). A transaction-level model (register array plus
// pending AW/W queues) predicts every bus output and reg_out each cycle.
// ---------------------------------------------------------------------------
module tb_axi_lite_reg_slave;

    localparam int          NR  = 8;
    localparam logic [7:0]  ROM = 8'h02;
    localparam logic [31:0] RV  = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic aclk    = 1'b0;
    logic aresetn = 1'b1;
    always #5 aclk = ~aclk;

    axi_lite_reg_slave_if bus ();
    logic [NR*32-1:0] ro_in;
    logic [NR*32-1:0] reg_out;
    logic             wr_state, rd_state;

    axi_lite_reg_slave #(
        .NUM_REGS    (NR),
        .RO_MASK     (ROM),
        .RESET_VALUE (RV)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .bus        (bus),
        .ro_in      (ro_in),
        .reg_out    (reg_out),
        .wr_state_o (wr_state),
        .rd_state_o (rd_state)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [NR];
    logic        m_bvalid = 1'b0;
    logic [1:0]  m_bresp  = 2'b00;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata  = '0;
    logic [1:0]  m_rresp  = 2'b00;
    logic [31:0] aw_q [$];
    logic [35:0] w_q [$];
    logic        m_aw_hs, m_w_hs, m_ar_hs;

    function automatic void model_read(input logic [31:0] addr, output logic [31:0] d,
                                       output logic [1:0] r);
        logic [29:0] idx = addr[31:2];
        if (idx >= NR) begin
            d = '0; r = 2'b10;
        end else if (ROM[idx]) begin
            d = ro_in[32*idx +: 32]; r = 2'b00;
        end else begin
            d = m_regs[idx]; r = 2'b00;
        end
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [35:0] sd);
        logic [29:0] idx = addr[31:2];
        if (idx >= NR || ROM[idx]) begin
            m_bresp = 2'b10;
        end else begin
            m_bresp = 2'b00;
            for (int k = 0; k < 4; k++)
                if (sd[32+k]) m_regs[idx][8*k +: 8] = sd[8*k +: 8];
        end
    endfunction

    function automatic logic [NR*32-1:0] exp_reg_out();
        logic [NR*32-1:0] v;
        for (int i = 0; i < NR; i++) v[32*i +: 32] = ROM[i] ? 32'h0 : m_regs[i];
        return v;
    endfunction

    initial for (int i = 0; i < NR; i++) m_regs[i] = RV;

    // Inputs are driven on the falling edge, so they are stable here.
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NR; i++) m_regs[i] = RV;
            m_bvalid = 1'b0; m_bresp = 2'b00;
            m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
            aw_q.delete(); w_q.delete();
        end else begin
            m_aw_hs = bus.awvalid && !m_bvalid && (aw_q.size() == 0);
            m_w_hs  = bus.wvalid  && !m_bvalid && (w_q.size() == 0);
            m_ar_hs = bus.arvalid && !m_rvalid;
            // Read first: a read on the commit edge sees the old value.
            if (m_ar_hs) begin
                model_read(bus.araddr, m_rdata, m_rresp);
                m_rvalid = 1'b1;
            end else if (m_rvalid && bus.rready) begin
                m_rvalid = 1'b0;
            end
            if (m_bvalid) begin
                if (bus.bready) m_bvalid = 1'b0;
            end else begin
                if (m_aw_hs) aw_q.push_back(bus.awaddr);
                if (m_w_hs)  w_q.push_back({bus.wstrb, bus.wdata});
                if (aw_q.size() > 0 && w_q.size() > 0) begin
                    model_write(aw_q.pop_front(), w_q.pop_front());
                    m_bvalid = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge aclk) begin
        if (cmp_en) begin
            chk("awready", bus.awready, !m_bvalid && aw_q.size() == 0);
            chk("wready",  bus.wready,  !m_bvalid && w_q.size() == 0);
            chk("bvalid",  bus.bvalid,  m_bvalid);
            chk("bresp",   bus.bresp,   m_bresp);
            chk("arready", bus.arready, !m_rvalid);
            chk("rvalid",  bus.rvalid,  m_rvalid);
            chk("rdata",   bus.rdata,   m_rdata);
            chk("rresp",   bus.rresp,   m_rresp);
            chk("reg_out", reg_out,     exp_reg_out());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp, output int lat);
        int cyc = 0, bcyc = 0, c_cyc = 0;
        bit aw_pend = 1, w_pend = 1, b_pend = 1;
        bit aw_hs, w_hs, b_hs;
        resp = 2'bxx; lat = -1;
        while ((aw_pend || w_pend || b_pend) && cyc < 200) begin
            @(negedge aclk);
            bus.awvalid = aw_pend && cyc >= aw_dly;
            bus.awaddr  = addr;
            bus.awprot  = 3'($urandom);
            bus.wvalid  = w_pend && cyc >= w_dly;
            bus.wdata   = data;
            bus.wstrb   = strb;
            bus.bready  = !aw_pend && !w_pend && b_pend && bcyc >= b_dly;
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            b_hs  = bus.bready && bus.bvalid;
            if (b_hs) resp = bus.bresp;
            @(posedge aclk);
            if (!aw_pend && !w_pend) bcyc++;
            if (aw_hs) begin aw_pend = 0; c_cyc = cyc; end
            if (w_hs)  begin w_pend = 0;  c_cyc = cyc; end
            if (b_hs)  begin b_pend = 0;  lat = cyc - c_cyc; end
            cyc++;
        end
        chk("write_timeout", b_pend, 1'b0);
        @(negedge aclk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp, output int lat);
        int cyc = 0, rcyc = 0, h_cyc = 0;
        bit ar_pend = 1, r_pend = 1;
        bit ar_hs, r_hs;
        data = 'x; resp = 2'bxx; lat = -1;
        while ((ar_pend || r_pend) && cyc < 200) begin
            @(negedge aclk);
            bus.arvalid = ar_pend && cyc >= ar_dly;
            bus.araddr  = addr;
            bus.arprot  = 3'($urandom);
            bus.rready  = !ar_pend && r_pend && rcyc >= r_dly;
            ar_hs = bus.arvalid && bus.arready;
            r_hs  = bus.rready && bus.rvalid;
            if (r_hs) begin data = bus.rdata; resp = bus.rresp; end
            @(posedge aclk);
            if (!ar_pend) rcyc++;
            if (ar_hs) begin ar_pend = 0; h_cyc = cyc; end
            if (r_hs)  begin r_pend = 0;  lat = cyc - h_cyc; end
            cyc++;
        end
        chk("read_timeout", r_pend, 1'b0);
        @(negedge aclk);
        bus.arvalid = 1'b0; bus.rready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [1:0]  resp, rresp_v;
    logic [31:0] rd;
    int          wlat, rlat;
    logic [NR*32-1:0] snap;

    initial begin
        bus.awvalid = 0; bus.awaddr = 0; bus.awprot = 0;
        bus.wvalid  = 0; bus.wdata  = 0; bus.wstrb  = 0; bus.bready = 0;
        bus.arvalid = 0; bus.araddr = 0; bus.arprot = 0; bus.rready = 0;
        for (int i = 0; i < NR; i++) ro_in[32*i +: 32] = $urandom;
        ro_in[63:32] = 32'hCAFE_0001;

        #1 aresetn = 1'b0;
        #11;
        cmp_en = 1'b1;
        chk("rst_awready", bus.awready, 1'b1);
        chk("rst_wready",  bus.wready,  1'b1);
        chk("rst_arready", bus.arready, 1'b1);
        chk("rst_bvalid",  bus.bvalid,  1'b0);
        chk("rst_rvalid",  bus.rvalid,  1'b0);
        chk("rst_rdata",   bus.rdata,   32'h0);
        chk("rst_reg_out", reg_out,     '0);
        @(negedge aclk); @(negedge aclk);
        aresetn = 1'b1;

        // Full write, AW and W together, then read back (register 3).
        do_write(32'h0C, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, resp, wlat);
        chk("t1_bresp", resp, 2'b00);
        chk("t1_blat",  wlat, 1);
        chk("t1_reg",   reg_out[127:96], 32'hDEAD_BEEF);
        do_read(32'h0C, 0, 0, rd, rresp_v, rlat);
        chk("t1_rdata", rd, 32'hDEAD_BEEF);
        chk("t1_rresp", rresp_v, 2'b00);
        chk("t1_rlat",  rlat, 1);

        // W three cycles ahead of AW, partial strobes.
        do_write(32'h00, 32'hAABB_CCDD, 4'hF, 0, 0, 0, resp, wlat);
        do_write(32'h00, 32'h1234_5678, 4'b0101, 3, 0, 0, resp, wlat);
        chk("t2_bresp", resp, 2'b00);
        chk("t2_reg",   reg_out[31:0], 32'hAA34_CC78);

        // Out of range.
        snap = reg_out;
        do_write(32'h20, 32'h5555_5555, 4'hF, 0, 1, 0, resp, wlat);
        chk("oor_bresp", resp, 2'b10);
        chk("oor_regs",  reg_out, snap);
        do_read(32'h20, 0, 0, rd, rresp_v, rlat);
        chk("oor_rdata", rd, 32'h0);
        chk("oor_rresp", rresp_v, 2'b10);

        // Read-only register 1.
        do_write(32'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp, wlat);
        chk("ro_bresp", resp, 2'b10);
        do_read(32'h06, 0, 0, rd, rresp_v, rlat);
        chk("ro_rdata", rd, 32'hCAFE_0001);
        chk("ro_rresp", rresp_v, 2'b00);
        chk("ro_reg",   reg_out[63:32], 32'h0);

        // Backpressure on both response channels for 5 cycles.
        fork
            do_write(32'h08, 32'h0000_0055, 4'hF, 0, 0, 5, resp, wlat);
            do_read(32'h0C, 0, 5, rd, rresp_v, rlat);
        join
        chk("bp_bresp", resp, 2'b00);
        chk("bp_blat",  wlat, 6);
        chk("bp_rdata", rd, 32'hDEAD_BEEF);
        chk("bp_rlat",  rlat, 6);

        // Read captured on the commit edge returns the old value.
        do_write(32'h14, 32'h1111_1111, 4'hF, 0, 0, 0, resp, wlat);
        fork
            do_write(32'h14, 32'h2222_2222, 4'hF, 0, 0, 0, resp, wlat);
            do_read(32'h14, 0, 0, rd, rresp_v, rlat);
        join
        chk("col_old", rd, 32'h1111_1111);
        do_read(32'h14, 0, 0, rd, rresp_v, rlat);
        chk("col_new", rd, 32'h2222_2222);

        // Random concurrent traffic, including unaligned and out-of-range.
        for (int it = 0; it < 150; it++) begin
            logic [31:0] wa, ra, wd;
            logic [3:0]  ws;
            int a0, a1, a2, a3, a4;
            bit dw, dr;
            logic [1:0]  r0, r1;
            logic [31:0] d1;
            int l0, l1;
            wa = ($urandom_range(0, 9) * 4) + $urandom_range(0, 3);
            ra = ($urandom_range(0, 9) * 4) + $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) wa = 32'h8000_0000 | wa;
            if ($urandom_range(0, 15) == 0) ra = 32'h4000_0000 | ra;
            wd = $urandom; ws = 4'($urandom);
            a0 = $urandom_range(0, 4); a1 = $urandom_range(0, 4); a2 = $urandom_range(0, 3);
            a3 = $urandom_range(0, 4); a4 = $urandom_range(0, 3);
            dw = $urandom_range(0, 3) != 0; dr = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 7) == 0) ro_in[32*$urandom_range(0, NR-1) +: 32] = $urandom;
            fork
                begin if (dw) do_write(wa, wd, ws, a0, a1, a2, r0, l0); end
                begin if (dr) do_read(ra, a3, a4, d1, r1, l1); end
            join
        end

        // Asynchronous reset after only the AW handshake.
        @(negedge aclk);
        bus.awvalid = 1'b1; bus.awaddr = 32'h1C; bus.awprot = 3'h0;
        @(posedge aclk);
        #3;
        bus.awvalid = 1'b0;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_awready", bus.awready, 1'b1);
        chk("mid_rst_wready",  bus.wready,  1'b1);
        chk("mid_rst_bvalid",  bus.bvalid,  1'b0);
        chk("mid_rst_reg_out", reg_out,     '0);
        @(negedge aclk); @(negedge aclk);
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        chk("post_rst_bvalid", bus.bvalid, 1'b0);
        do_write(32'h1C, 32'h0BAD_F00D, 4'hF, 0, 0, 0, resp, wlat);
        chk("post_rst_bresp", resp, 2'b00);
        do_read(32'h1C, 0, 0, rd, rresp_v, rlat);
        chk("post_rst_rdata", rd, 32'h0BAD_F00D);

        repeat (2) @(negedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
